// File: rtl/bnn_pkg.sv
// Shared command codes, loader state encoding and a saturating counter helper
// for the BNN image loader.
package bnn_pkg;

    localparam logic [7:0] CMD_LOAD  = 8'hA5;
    localparam logic [7:0] CMD_ABORT = 8'h5A;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_LOAD,
        LD_HOLD
    } loader_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/bnn_timeout_counter.sv
// Inter-byte idle timer: a down-counter that is reloaded by clr and signals
// expiry on the MAX-th consecutive enabled cycle after the reload.
module bnn_timeout_counter #(
    parameter int unsigned MAX = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned W = (MAX > 2) ? $clog2(MAX) : 1;
    localparam logic [W-1:0] RELOAD = W'(MAX - 1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = RELOAD;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Terminal count reached while still idle: the caller aborts this cycle.
    assign expired = en && !clr && (count_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= RELOAD;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bnn_image_loader.sv
// Command decoder and payload assembler between the UART receiver and the BNN
// core; holds a complete image behind a valid/ready handshake.
module bnn_image_loader
    import bnn_pkg::*;
#(
    parameter int unsigned IMG_BITS       = 256,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [IMG_BITS-1:0] img_bits,
    output logic                img_valid,
    input  logic                img_ready,
    output logic                loader_ready,
    output logic                err_unknown,
    output logic                err_timeout,
    output logic                err_overrun,
    output logic [7:0]          err_count
);

    localparam int unsigned IMG_BYTES = IMG_BITS / 8;
    localparam int unsigned CNT_W     = (IMG_BYTES > 1) ? $clog2(IMG_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(IMG_BYTES - 1);

    loader_state_t       state_q, state_d;
    logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
    logic [IMG_BITS-1:0] img_q, img_d;
    logic                img_valid_q, img_valid_d;
    logic                loader_ready_q, loader_ready_d;
    logic                err_unknown_q, err_unknown_d;
    logic                err_timeout_q, err_timeout_d;
    logic                err_overrun_q, err_overrun_d;
    logic [7:0]          err_count_q, err_count_d;

    logic                tmr_clr;
    logic                tmr_en;
    logic                tmr_expired;

    bnn_timeout_counter #(
        .MAX (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LD_IDLE: begin
                if (rx_valid && (rx_data == CMD_LOAD)) begin
                    state_d = LD_LOAD;
                end
            end
            LD_LOAD: begin
                if (rx_valid && (byte_cnt_q == LAST_BYTE)) begin
                    state_d = LD_HOLD;
                end else if (tmr_expired) begin
                    state_d = LD_IDLE;
                end
            end
            LD_HOLD: begin
                if (img_valid_q && img_ready) begin
                    state_d = LD_IDLE;
                end
            end
            default: state_d = LD_IDLE;
        endcase
    end

    always_comb begin
        byte_cnt_d    = byte_cnt_q;
        img_d         = img_q;
        tmr_clr       = 1'b0;
        tmr_en        = 1'b0;
        err_unknown_d = 1'b0;
        err_timeout_d = 1'b0;
        err_overrun_d = 1'b0;
        case (state_q)
            LD_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_LOAD) begin
                        byte_cnt_d = '0;
                        tmr_clr    = 1'b1;
                    end else begin
                        err_unknown_d = 1'b1;
                    end
                end
            end
            LD_LOAD: begin
                if (rx_valid) begin
                    img_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
                    tmr_clr = 1'b1;
                    // Counter stops at the last slot; the exit to HOLD ends the load.
                    if (byte_cnt_q != LAST_BYTE) begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end else begin
                    tmr_en        = 1'b1;
                    err_timeout_d = tmr_expired;
                end
            end
            LD_HOLD: begin
                err_overrun_d = rx_valid;
            end
            default: ;
        endcase
        img_valid_d    = (state_d == LD_HOLD);
        loader_ready_d = (state_d != LD_HOLD);
        err_count_d    = (err_unknown_d || err_timeout_d || err_overrun_d)
                         ? sat_inc8(err_count_q) : err_count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_q     <= '0;
            img_q          <= '0;
            img_valid_q    <= 1'b0;
            loader_ready_q <= 1'b1;
            err_unknown_q  <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_overrun_q  <= 1'b0;
            err_count_q    <= 8'd0;
        end else begin
            byte_cnt_q     <= byte_cnt_d;
            img_q          <= img_d;
            img_valid_q    <= img_valid_d;
            loader_ready_q <= loader_ready_d;
            err_unknown_q  <= err_unknown_d;
            err_timeout_q  <= err_timeout_d;
            err_overrun_q  <= err_overrun_d;
            err_count_q    <= err_count_d;
        end
    end

    assign img_bits     = img_q;
    assign img_valid    = img_valid_q;
    assign loader_ready = loader_ready_q;
    assign err_unknown  = err_unknown_q;
    assign err_timeout  = err_timeout_q;
    assign err_overrun  = err_overrun_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_bnn_image_loader.sv
// Self-checking bench for bnn_image_loader: randomized payloads and gaps checked
// against a byte-array image model and an integer error tally.
module tb_bnn_image_loader;
    import bnn_pkg::*;

    localparam int IMG_BITS = 256;
    localparam int NB       = IMG_BITS / 8;
    localparam int TO       = 100;

    logic                clk = 1'b0;
    logic                rst;
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic [IMG_BITS-1:0] img_bits;
    logic                img_valid;
    logic                img_ready;
    logic                loader_ready;
    logic                err_unknown;
    logic                err_timeout;
    logic                err_overrun;
    logic [7:0]          err_count;

    int checks = 0;
    int errors = 0;
    int exp_errs = 0;
    logic [7:0] exp_img [NB];
    logic [7:0] pay [NB];

    bnn_image_loader #(
        .IMG_BITS       (IMG_BITS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .img_bits     (img_bits),
        .img_valid    (img_valid),
        .img_ready    (img_ready),
        .loader_ready (loader_ready),
        .err_unknown  (err_unknown),
        .err_timeout  (err_timeout),
        .err_overrun  (err_overrun),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [IMG_BITS-1:0] pack_img();
        logic [IMG_BITS-1:0] v;
        for (int i = 0; i < NB; i++) v[8*i +: 8] = exp_img[i];
        return v;
    endfunction

    function automatic logic [7:0] exp_cnt();
        return (exp_errs > 255) ? 8'hFF : exp_errs[7:0];
    endfunction

    task automatic strobe(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
    endtask

    task automatic quiet(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic load_image(input int maxgap);
        int g;
        for (int i = 0; i < NB; i++) pay[i] = 8'($urandom);
        pay[5] = CMD_LOAD;
        pay[9] = CMD_ABORT;
        strobe(CMD_LOAD);
        quiet(1);
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            if (i == NB - 1) begin
                checks++;
                if (img_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL load_early_valid got %b want 0", img_valid);
                end
            end
            rx_data  = pay[i];
            rx_valid = 1'b1;
            if (i < NB - 1) begin
                g = $urandom_range(maxgap, 0);
                if (g > 0) quiet(g);
            end
        end
        quiet(1);
        exp_img = pay;
        checks++;
        if (img_valid !== 1'b1 || loader_ready !== 1'b0 || img_bits !== pack_img()) begin
            errors++;
            $display("FAIL load_done valid=%b ready=%b bits=%h want valid=1 ready=0 bits=%h",
                     img_valid, loader_ready, img_bits, pack_img());
        end
    endtask

    task automatic release_image();
        @(negedge clk);
        img_ready = 1'b1;
        @(negedge clk);
        img_ready = 1'b0;
        checks++;
        if (img_valid !== 1'b0 || loader_ready !== 1'b1 || img_bits !== pack_img()) begin
            errors++;
            $display("FAIL release valid=%b ready=%b bits=%h want valid=0 ready=1 bits=%h",
                     img_valid, loader_ready, img_bits, pack_img());
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; img_ready = 1'b0;
        for (int i = 0; i < NB; i++) exp_img[i] = 8'h00;
        #3 rst = 1'b1;
        #1;
        checks++;
        if (img_bits !== '0 || img_valid !== 1'b0 || loader_ready !== 1'b1 ||
            err_unknown !== 1'b0 || err_timeout !== 1'b0 || err_overrun !== 1'b0 ||
            err_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_async valid=%b ready=%b errs=%b%b%b cnt=%0d bits_nz=%b",
                     img_valid, loader_ready, err_unknown, err_timeout, err_overrun,
                     err_count, |img_bits);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        quiet(2);
        checks++;
        if (loader_ready !== 1'b1 || img_valid !== 1'b0 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_release ready=%b valid=%b cnt=%0d want 1 0 0",
                     loader_ready, img_valid, err_count);
        end
    endtask

    task automatic test_load_seq();
        logic [IMG_BITS-1:0] snap;
        strobe(CMD_LOAD);
        quiet(9);
        for (int i = 0; i < NB; i++) begin
            if (i == NB - 1) begin
                checks++;
                if (img_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL seq_early_valid got %b want 0", img_valid);
                end
            end
            strobe(8'(i));
            exp_img[i] = 8'(i);
            quiet((i == NB - 1) ? 1 : 9);
        end
        checks++;
        if (img_valid !== 1'b1 || img_bits[7:0] !== 8'h00 || img_bits[255:248] !== 8'h1F ||
            img_bits !== pack_img()) begin
            errors++;
            $display("FAIL seq_valid valid=%b lo=%h hi=%h want 1 00 1F", img_valid,
                     img_bits[7:0], img_bits[255:248]);
        end
        snap = pack_img();
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            checks++;
            if (img_valid !== 1'b1 || loader_ready !== 1'b0 || img_bits !== snap) begin
                errors++;
                $display("FAIL hold_stable cyc=%0d valid=%b ready=%b want 1 0", c,
                         img_valid, loader_ready);
            end
        end
        release_image();
    endtask

    task automatic test_unknown();
        strobe(8'h33);
        quiet(1);
        exp_errs++;
        checks++;
        if (err_unknown !== 1'b1 || err_count !== exp_cnt() || loader_ready !== 1'b1 ||
            img_valid !== 1'b0) begin
            errors++;
            $display("FAIL unknown_33 pulse=%b cnt=%0d want 1 %0d", err_unknown, err_count,
                     exp_cnt());
        end
        quiet(1);
        checks++;
        if (err_unknown !== 1'b0) begin
            errors++;
            $display("FAIL unknown_pulse_width got %b want 0", err_unknown);
        end
        strobe(CMD_ABORT);
        quiet(1);
        exp_errs++;
        checks++;
        if (err_unknown !== 1'b1 || err_count !== exp_cnt()) begin
            errors++;
            $display("FAIL unknown_abort pulse=%b cnt=%0d want 1 %0d", err_unknown, err_count,
                     exp_cnt());
        end
        img_ready = 1'b1;
        quiet(3);
        img_ready = 1'b0;
        checks++;
        if (img_valid !== 1'b0 || loader_ready !== 1'b1 || err_count !== exp_cnt()) begin
            errors++;
            $display("FAIL ready_idle valid=%b ready=%b cnt=%0d", img_valid, loader_ready,
                     err_count);
        end
        load_image(6);
        release_image();
    endtask

    task automatic test_timeout();
        int first_hit = -1;
        int hits = 0;
        logic saw_valid = 1'b0;
        strobe(CMD_LOAD);
        quiet(1);
        for (int i = 0; i < 5; i++) begin
            exp_img[i] = 8'($urandom);
            strobe(exp_img[i]);
            quiet((i == 4) ? 1 : 1 + $urandom_range(5, 0));
        end
        for (int c = 1; c <= TO + 10; c++) begin
            @(negedge clk);
            if (err_timeout === 1'b1) begin
                hits++;
                if (first_hit < 0) first_hit = c;
            end
            if (img_valid !== 1'b0) saw_valid = 1'b1;
        end
        exp_errs++;
        checks++;
        if (hits != 1 || first_hit != TO) begin
            errors++;
            $display("FAIL timeout_time pulses=%0d at=%0d want 1 at %0d", hits, first_hit, TO);
        end
        checks++;
        if (saw_valid || err_count !== exp_cnt() || loader_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_state saw_valid=%b cnt=%0d want 0 %0d", saw_valid,
                     err_count, exp_cnt());
        end
        checks++;
        if (img_bits !== pack_img()) begin
            errors++;
            $display("FAIL timeout_partial got %h want %h", img_bits, pack_img());
        end
        load_image(20);
        release_image();
    endtask

    task automatic test_overrun();
        load_image(3);
        quiet(3);
        strobe(8'($urandom));
        quiet(1);
        exp_errs++;
        checks++;
        if (err_overrun !== 1'b1 || img_valid !== 1'b1 || img_bits !== pack_img() ||
            err_count !== exp_cnt()) begin
            errors++;
            $display("FAIL overrun_hold pulse=%b valid=%b cnt=%0d want 1 1 %0d", err_overrun,
                     img_valid, err_count, exp_cnt());
        end
        @(negedge clk);
        rx_data = 8'h77; rx_valid = 1'b1; img_ready = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0; img_ready = 1'b0;
        exp_errs++;
        checks++;
        if (err_overrun !== 1'b1 || img_valid !== 1'b0 || loader_ready !== 1'b1 ||
            img_bits !== pack_img() || err_count !== exp_cnt()) begin
            errors++;
            $display("FAIL overrun_ready pulse=%b valid=%b ready=%b cnt=%0d want 1 0 1 %0d",
                     err_overrun, img_valid, loader_ready, err_count, exp_cnt());
        end
        load_image(2);
        release_image();
    endtask

    task automatic test_back_to_back();
        load_image(0);
        release_image();
        load_image(0);
        release_image();
    endtask

    task automatic test_reset_midload();
        logic [7:0] b;
        strobe(CMD_LOAD);
        quiet(1);
        for (int i = 0; i < 10; i++) begin
            strobe(8'($urandom));
            quiet(1);
        end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        exp_errs = 0;
        for (int i = 0; i < NB; i++) exp_img[i] = 8'h00;
        checks++;
        if (img_bits !== pack_img() || img_valid !== 1'b0 || loader_ready !== 1'b1 ||
            err_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_midload valid=%b ready=%b cnt=%0d bits_nz=%b", img_valid,
                     loader_ready, err_count, |img_bits);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NB + 300; i++) begin
            b = 8'($urandom);
            if (b == CMD_LOAD) b = 8'h00;
            strobe(b);
            quiet(1);
            exp_errs++;
            checks++;
            if (err_unknown !== 1'b1 || err_count !== exp_cnt() || img_valid !== 1'b0) begin
                errors++;
                $display("FAIL unknown_stress n=%0d pulse=%b cnt=%0d want 1 %0d", i,
                         err_unknown, err_count, exp_cnt());
            end
        end
        checks++;
        if (err_count !== 8'hFF) begin
            errors++;
            $display("FAIL err_saturate got %0d want 255", err_count);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_seq();
        test_unknown();
        test_timeout();
        test_overrun();
        test_back_to_back();
        test_reset_midload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
